// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state, grant and width definitions for mem_arbiter
package mem_arbiter_pkg;

  localparam int         CNT_W   = 8;
  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_e;

  // Round-robin pick: on contention the side that did not win last time goes next.
  function automatic grant_e arb_pick(input logic if_req, input logic dm_req, input grant_e last);
    grant_e pick;
    if (if_req && dm_req) begin
      if (last == GRANT_IF) pick = GRANT_DM;
      else                  pick = GRANT_IF;
    end else if (dm_req) begin
      pick = GRANT_DM;
    end else begin
      pick = GRANT_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - BUSY-cycle counter that flags expiry at TIMEOUT
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // Counting stops at the limit so a stalled access cannot wrap back to a live count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == LP_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one RAM between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [3:0]        dm_sel_i,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic [DATA_W-1:0] dm_data_o,
  output logic              dm_ack_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_data_ready_i,
  output logic              timeout_err_o
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  grant_e     r_grant;
  grant_e     r_last_grant;
  grant_e     w_pick;

  logic w_do_grant;
  logic w_done_ok;
  logic w_done_to;
  logic w_expire;

  logic              r_ram_ce;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [3:0]        r_ram_sel;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_dm_data;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              r_timeout_err;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .i_clr    (w_do_grant),
    .i_en     (r_state == ARB_BUSY),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A ready seen on the expiry edge still wins, so late-but-valid data is not discarded.
  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    w_pick      = arb_pick(if_req_i, dm_req_i, r_last_grant);
    case (r_state)
      ARB_IDLE: begin
        if (if_req_i || dm_req_i) begin
          w_do_grant  = 1'b1;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (ram_data_ready_i) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ARB_DONE;
        end else if (w_expire) begin
          w_done_to   = 1'b1;
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant       <= GRANT_IF;
      r_last_grant  <= GRANT_IF;
      r_ram_ce      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_sel     <= '0;
      r_ram_wdata   <= '0;
      r_if_data     <= '0;
      r_dm_data     <= '0;
      r_if_ack      <= 1'b0;
      r_dm_ack      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_if_ack      <= 1'b0;
      r_dm_ack      <= 1'b0;
      r_timeout_err <= 1'b0;

      if (w_do_grant) begin
        r_grant  <= w_pick;
        r_ram_ce <= 1'b1;
        if (w_pick == GRANT_DM) begin
          r_ram_addr  <= dm_addr_i;
          r_ram_we    <= dm_we_i;
          r_ram_sel   <= dm_sel_i;
          r_ram_wdata <= dm_data_i;
        end else begin
          r_ram_addr  <= if_addr_i;
          r_ram_we    <= 1'b0;
          r_ram_sel   <= SEL_ALL;
          r_ram_wdata <= '0;
        end
      end

      // Aborted accesses return zero so a stale word is never mistaken for data.
      if (w_done_ok || w_done_to) begin
        r_ram_ce      <= 1'b0;
        r_ram_we      <= 1'b0;
        r_timeout_err <= w_done_to;
        if (r_grant == GRANT_DM) begin
          r_dm_ack  <= 1'b1;
          r_dm_data <= w_done_ok ? ram_data_i : '0;
        end else begin
          r_if_ack  <= 1'b1;
          r_if_data <= w_done_ok ? ram_data_i : '0;
        end
      end

      if (r_state == ARB_DONE) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign ram_ce_o      = r_ram_ce;
  assign ram_we_o      = r_ram_we;
  assign ram_addr_o    = r_ram_addr;
  assign ram_sel_o     = r_ram_sel;
  assign ram_data_o    = r_ram_wdata;
  assign if_data_o     = r_if_data;
  assign if_ack_o      = r_if_ack;
  assign dm_data_o     = r_dm_data;
  assign dm_ack_o      = r_dm_ack;
  assign timeout_err_o = r_timeout_err;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported `data_ram` between the core's instruction-fetch path and its load/store path, so one unified memory can serve both.
- Sits between `openmips` and the RAM in the SOPC top level.
- Sequences each access through a grant/busy/done FSM with round-robin fairness.
- Forwards the RAM's multi-cycle `data_ready` completion back to the granted requester.
- Bounds every access with a timeout counter.

## Interface
Parameters:
- `ADDR_W`, 32: address width (matches `InstAddrBus`/`RegBus`).
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: max BUSY cycles before abort; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req_i`  in  1  fetch request, level, held until ack.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_data_o`  out  DATA_W  fetched word, valid while `if_ack_o`.
- `if_ack_o`  out  1  one-cycle fetch completion.
- `dm_req_i`  in  1  data request, level, held until ack.
- `dm_we_i`  in  1  1 = write.
- `dm_addr_i`  in  ADDR_W  data address.
- `dm_sel_i`  in  4  byte lanes.
- `dm_data_i`  in  DATA_W  write data.
- `dm_data_o`  out  DATA_W  read data, valid while `dm_ack_o`.
- `dm_ack_o`  out  1  one-cycle data completion (read or write).
- `ram_ce_o`, `ram_we_o`  out  1  RAM enable / write enable.
- `ram_addr_o`  out  ADDR_W  RAM address.
- `ram_sel_o`  out  4  RAM byte lanes.
- `ram_data_o`  out  DATA_W  RAM write data.
- `ram_data_i`  in  DATA_W  RAM read data.
- `ram_data_ready_i`  in  1  RAM completion.
- `timeout_err_o`  out  1  one-cycle pulse coincident with an aborted ack.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: evaluate requests.
    - Exactly one requesting: grant it.
    - Both requesting: grant the one not in `last_grant`.
    - Neither: stay in IDLE.
  - On grant: register address, we, sel and write data; go to BUSY.
    - Fetch grant forces `ram_we_o`=0 and `ram_sel_o`=4'hF.
  - BUSY: `ram_ce_o`=1 from the registered request; requester inputs are ignored.
    - `ram_data_ready_i`=1: capture `ram_data_i` into the granted `*_data_o` and go to DONE.
    - Timeout counter reaches `TIMEOUT` first: go to DONE with data 0 and set the error flag.
  - DONE: `ram_ce_o`=0; granted ack=1; `timeout_err_o`=error flag; update `last_grant`; next state IDLE unconditionally.
- Request drop rule: the requester must drop (or re-present) its request by the edge ending DONE. The IDLE cycle after DONE re-samples.
- Timeout counter: 8-bit, cleared on BUSY entry, +1 per BUSY cycle.
- `ram_data_ready_i` in IDLE or DONE is ignored.
- Outputs are registered only: no combinational path from any input to any output.
- Reset values:
  - state IDLE; `last_grant`=IF, so data wins the first contention.
  - All outputs 0; data registers 0; counter 0.
- Reset asserted mid-BUSY: all outputs clear immediately (asynchronous); the access is dropped with no ack.

## Timing
- Request high at edge k in IDLE → BUSY from k, `ram_ce_o`=1 from k.
- `ram_data_ready_i` sampled high at edge m → DONE from m; ack and data valid for exactly the cycle m..m+1; IDLE at m+1.
- Minimum request-to-ack: 1 cycle if ready at the first BUSY edge; one transfer per 3 cycles minimum.
- Timeout: ack asserted `TIMEOUT`+1 edges after the grant edge.
- Contention: alternating grants; neither side waits more than one foreign transfer.

## Structure
- Shared defines/package: state encoding (`ARB_IDLE`/`ARB_BUSY`/`ARB_DONE`), grant IDs (`GRANT_IF`/`GRANT_DM`), width macros reused from `defines.v`.
- One sub-module: `mem_arb_timer` (clear/enable/expire counter, parameter `TIMEOUT`).
- Top-level change: `openmips_min_sopc` instantiates `mem_arbiter` between `openmips` and `data_ram`.

## Test plan
- Fetch only: `if_req_i`=1, addr 0x10, RAM ready 2 cycles after ce with 0xDEADBEEF → `if_ack_o` pulse, `if_data_o`=0xDEADBEEF, `ram_we_o`=0, `ram_sel_o`=F.
- Write: dm write addr 0x40, sel 4'b0011, data 0x1234 → `ram_we_o`=1 with sel 3 and data 0x1234 during BUSY; `dm_ack_o` one cycle after ready.
- Contention from reset: both requesting continuously → grant order DM, IF, DM, IF; each ack one cycle wide; IDLE cycle between transfers.
- Timeout with `TIMEOUT`=4, RAM never ready → ack plus `timeout_err_o` 5 edges after grant; data 0; next request served normally.
- `rst` pulled low mid-BUSY → `ram_ce_o` and acks go 0 immediately with no ack. After release, a pending request is granted fresh; `last_grant` is back to IF.
- Spurious `ram_data_ready_i` in IDLE → no ack, state unchanged.
